chs_conf_serializer: RTL and testbench
======================================

Name: chs_conf_serializer

Overview:
Parametrised serial loader and population counter for cool/heat-system configuration words. Captures a WIDTH-bit configuration word, shifts it out one bit per clock (MSB- or LSB-first), and counts the one bits as they pass. On completion it reports the final ones count and an even-parity flag. Sits between the configuration register bank and the serial actuator interface of the cool/heat system.

Parameters:
WIDTH, 8, configuration word width in bits; legal range 2..64.
MSB_FIRST, 1, 1 = shift bit WIDTH-1 first; 0 = shift bit 0 first.
CNT_W, $clog2(WIDTH+1), width of the ones count; must hold the value WIDTH.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
load  input  1  request to capture chs_conf; honoured only when ready=1.
chs_conf  input  WIDTH  configuration word to serialise.
abort  input  1  cancels an in-progress shift.
ready  output  1  high in IDLE; block accepts load.
out_bit  output  1  current serial bit; qualified by out_valid.
out_valid  output  1  high for exactly WIDTH consecutive cycles per accepted load, unless aborted.
done  output  1  single-cycle pulse when a word completes.
ones_count  output  CNT_W  number of ones in the last completed word.
is_even  output  1  ~ones_count[0]; even parity of the last completed word.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, shift register=0, running count=0, bit index=0; outputs: ready=1, out_bit=0, out_valid=0, done=0, ones_count=0, is_even=1.
- All outputs are registered; no combinational path from any input to any output.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: ready=1. At an edge with load=1 and abort=0: capture chs_conf, clear the running count and bit index, and go to SHIFT. An edge with load=1 and abort=1 is ignored (abort has priority).
- SHIFT: ready=0, out_valid=1. out_bit is the current head bit: chs_conf[WIDTH-1-i] for MSB_FIRST=1, chs_conf[i] otherwise, where i = 0..WIDTH-1.
  - Each edge: running count += out_bit; shift register advances; i += 1.
  - On the edge where i = WIDTH-1, go to DONE and latch ones_count = running count + out_bit.
- Latency: load sampled at edge k -> out_valid high during cycles k+1 .. k+WIDTH -> done=1 in cycle k+WIDTH+1 -> ready=1 again in cycle k+WIDTH+2.
- DONE: done=1 for one cycle, out_valid=0, ready=0. ones_count and is_even are already valid in this cycle. Next state is IDLE unconditionally.
- ones_count and is_even hold their values until the next completed word. They are not cleared on load or abort.
- load while ready=0 (SHIFT or DONE) is ignored. No queuing; chs_conf changes during SHIFT have no effect.
- abort=1 at an edge in SHIFT: go to IDLE, out_valid=0, and clear the running count. No done pulse. ones_count and is_even keep their previous values. abort in DONE is ignored and done still pulses.
- Width rule: the running count is CNT_W bits and never wraps, since its maximum is WIDTH.
- Reset asserted mid-SHIFT: immediate return to reset values. No done pulse and no partial result.
- out_bit=0 whenever out_valid=0.

Test Plan:
- Reset then WIDTH=8, MSB_FIRST=1, load chs_conf=8'b1011_0010 -> out_bit sequence 1,0,1,1,0,0,1,0 over 8 cycles with out_valid=1; done at cycle k+9; ones_count=4, is_even=1; ready=1 at k+10.
- WIDTH=8: load 8'hFF -> ones_count=8 (4'b1000), is_even=1. Back-to-back load 8'h00 on the first ready cycle -> ones_count=0, is_even=1. Then load 8'h07 -> ones_count=3, is_even=0.
- WIDTH=16, MSB_FIRST=0: load 16'h8001 -> first out_bit=1, then 14 zeros, last out_bit=1; ones_count=2 (CNT_W=5); done at k+17.
- After a completed word giving ones_count=3, load 8'hF0 and assert abort at the 3rd SHIFT cycle -> out_valid drops next cycle, no done, ones_count stays 3, ready=1. load and abort together in IDLE -> no capture.
- load 8'hAA, then assert load=1 with chs_conf=8'h01 during SHIFT -> ignored; result ones_count=4. Pull rst_n low mid-SHIFT asynchronously -> all outputs at reset values before the next clk edge.

Source files
------------

// File: rtl/chs_conf_serializer.sv
// Serial loader and population counter for cool/heat-system configuration words.
// Shifts a captured word out one bit per clock and reports its ones count and even parity.
module chs_conf_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] chs_conf,
    input  logic             abort,
    output logic             ready,
    output logic             out_bit,
    output logic             out_valid,
    output logic             done,
    output logic [CNT_W-1:0] ones_count,
    output logic             is_even
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] idx;

    logic [WIDTH-1:0] sreg_adv;
    logic             load_head;
    logic             next_head;
    logic [CNT_W-1:0] sum_cnt;

    // out_bit is registered, so the head of the advanced register is prepared one edge early.
    always_comb begin
        sreg_adv  = '0;
        load_head = 1'b0;
        next_head = 1'b0;
        if (MSB_FIRST) begin
            sreg_adv  = {sreg[WIDTH-2:0], 1'b0};
            load_head = chs_conf[WIDTH-1];
            next_head = sreg_adv[WIDTH-1];
        end else begin
            sreg_adv  = {1'b0, sreg[WIDTH-1:1]};
            load_head = chs_conf[0];
            next_head = sreg_adv[0];
        end
        sum_cnt = run_cnt + CNT_W'(out_bit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sreg       <= '0;
            run_cnt    <= '0;
            idx        <= '0;
            ready      <= 1'b1;
            out_bit    <= 1'b0;
            out_valid  <= 1'b0;
            done       <= 1'b0;
            ones_count <= '0;
            is_even    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (load && !abort) begin
                        sreg      <= chs_conf;
                        run_cnt   <= '0;
                        idx       <= '0;
                        out_bit   <= load_head;
                        out_valid <= 1'b1;
                        ready     <= 1'b0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        run_cnt   <= '0;
                        idx       <= '0;
                        out_bit   <= 1'b0;
                        out_valid <= 1'b0;
                        ready     <= 1'b1;
                        state     <= IDLE;
                    end else if (idx == LAST_IDX) begin
                        sreg       <= sreg_adv;
                        run_cnt    <= sum_cnt;
                        out_bit    <= 1'b0;
                        out_valid  <= 1'b0;
                        done       <= 1'b1;
                        ones_count <= sum_cnt;
                        is_even    <= ~sum_cnt[0];
                        state      <= DONE;
                    end else begin
                        sreg    <= sreg_adv;
                        run_cnt <= sum_cnt;
                        idx     <= idx + CNT_W'(1);
                        out_bit <= next_head;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chs_conf_serializer.sv
// Directed self-checking bench for chs_conf_serializer: an 8-bit MSB-first
// instance and a 16-bit LSB-first instance share the clock and reset.
module tb_chs_conf_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       load8, abort8;
    logic [7:0] conf8;
    logic       ready8, bit8, valid8, done8, even8;
    logic [3:0] ones8;

    logic        load16, abort16;
    logic [15:0] conf16;
    logic        ready16, bit16, valid16, done16, even16;
    logic [4:0]  ones16;

    int n_checks = 0;
    int n_fail   = 0;

    chs_conf_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut8 (
        .clk(clk), .rst_n(rst_n), .load(load8), .chs_conf(conf8), .abort(abort8),
        .ready(ready8), .out_bit(bit8), .out_valid(valid8), .done(done8),
        .ones_count(ones8), .is_even(even8)
    );

    chs_conf_serializer #(.WIDTH(16), .MSB_FIRST(1'b0)) dut16 (
        .clk(clk), .rst_n(rst_n), .load(load16), .chs_conf(conf16), .abort(abort16),
        .ready(ready16), .out_bit(bit16), .out_valid(valid16), .done(done16),
        .ones_count(ones16), .is_even(even16)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        load8 = 1'b0; abort8 = 1'b0; conf8 = 8'h00;
        load16 = 1'b0; abort16 = 1'b0; conf16 = 16'h0000;
        repeat (2) step();
        n_checks++;
        if ({ready8, bit8, valid8, done8, ones8, even8} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset8: got rdy/bit/vld/done/ones/even=%b%b%b%b/%0d/%b want 1000/0/1",
                     ready8, bit8, valid8, done8, ones8, even8);
        end
        n_checks++;
        if ({ready16, bit16, valid16, done16, ones16, even16} !== {1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset16: got rdy/bit/vld/done/ones/even=%b%b%b%b/%0d/%b want 1000/0/1",
                     ready16, bit16, valid16, done16, ones16, even16);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_msb_first();
        logic [7:0] exp_seq;
        exp_seq = 8'b1011_0010;
        conf8 = 8'b1011_0010;
        load8 = 1'b1;
        step();
        load8 = 1'b0;
        conf8 = 8'h00;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if ({valid8, bit8, ready8, done8} !== {1'b1, exp_seq[7-i], 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL msb_bit[%0d]: got vld/bit/rdy/done=%b%b%b%b want 1%b00",
                         i, valid8, bit8, ready8, done8, exp_seq[7-i]);
            end
            step();
        end
        n_checks++;
        if ({done8, valid8, bit8, ready8, ones8, even8} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1}) begin
            n_fail++;
            $display("FAIL msb_done: got done/vld/bit/rdy=%b%b%b%b ones=%0d even=%b want 1000 ones=4 even=1",
                     done8, valid8, bit8, ready8, ones8, even8);
        end
        step();
        n_checks++;
        if ({ready8, done8} !== 2'b10) begin
            n_fail++;
            $display("FAIL msb_ready: got rdy/done=%b%b want 10", ready8, done8);
        end
    endtask

    task automatic test_back_to_back();
        conf8 = 8'hFF;
        load8 = 1'b1;
        step();
        load8 = 1'b0;
        repeat (8) step();
        n_checks++;
        if ({done8, ones8, even8} !== {1'b1, 4'b1000, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_ff: got done=%b ones=%0d even=%b want done=1 ones=8 even=1", done8, ones8, even8);
        end
        step();
        n_checks++;
        if (ready8 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready: got %b want 1", ready8);
        end
        conf8 = 8'h00;
        load8 = 1'b1;
        step();
        load8 = 1'b0;
        n_checks++;
        if ({valid8, bit8, ones8, even8} !== {1'b1, 1'b0, 4'd8, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_hold: got vld=%b bit=%b ones=%0d even=%b want vld=1 bit=0 ones=8 even=1",
                     valid8, bit8, ones8, even8);
        end
        repeat (8) step();
        n_checks++;
        if ({done8, ones8, even8} !== {1'b1, 4'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_00: got done=%b ones=%0d even=%b want done=1 ones=0 even=1", done8, ones8, even8);
        end
        step();
        conf8 = 8'h07;
        load8 = 1'b1;
        step();
        load8 = 1'b0;
        repeat (8) step();
        n_checks++;
        if ({done8, ones8, even8} !== {1'b1, 4'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_07: got done=%b ones=%0d even=%b want done=1 ones=3 even=0", done8, ones8, even8);
        end
        step();
    endtask

    task automatic test_lsb_first();
        logic exp_bit;
        conf16 = 16'h8001;
        load16 = 1'b1;
        step();
        load16 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_bit = (i == 0) || (i == 15);
            n_checks++;
            if ({valid16, bit16, done16} !== {1'b1, exp_bit, 1'b0}) begin
                n_fail++;
                $display("FAIL lsb_bit[%0d]: got vld/bit/done=%b%b%b want 1%b0", i, valid16, bit16, done16, exp_bit);
            end
            step();
        end
        n_checks++;
        if ({done16, valid16, ones16, even16} !== {1'b1, 1'b0, 5'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL lsb_done: got done=%b vld=%b ones=%0d even=%b want done=1 vld=0 ones=2 even=1",
                     done16, valid16, ones16, even16);
        end
        step();
        n_checks++;
        if (ready16 !== 1'b1) begin
            n_fail++;
            $display("FAIL lsb_ready: got %b want 1", ready16);
        end
    endtask

    task automatic test_abort();
        logic seen_done;
        conf8 = 8'hF0;
        load8 = 1'b1;
        step();
        load8 = 1'b0;
        step();
        step();
        n_checks++;
        if ({valid8, bit8} !== 2'b11) begin
            n_fail++;
            $display("FAIL abort_pre: got vld/bit=%b%b want 11", valid8, bit8);
        end
        abort8 = 1'b1;
        step();
        abort8 = 1'b0;
        n_checks++;
        if ({valid8, bit8, ready8, done8, ones8, even8} !== {1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_drop: got vld/bit/rdy/done=%b%b%b%b ones=%0d even=%b want 0010 ones=3 even=0",
                     valid8, bit8, ready8, done8, ones8, even8);
        end
        seen_done = 1'b0;
        repeat (10) begin
            step();
            if (done8 === 1'b1) seen_done = 1'b1;
        end
        n_checks++;
        if ({seen_done, ones8} !== {1'b0, 4'd3}) begin
            n_fail++;
            $display("FAIL abort_nodone: got seen_done=%b ones=%0d want seen_done=0 ones=3", seen_done, ones8);
        end
        conf8 = 8'hFF;
        load8 = 1'b1;
        abort8 = 1'b1;
        step();
        load8 = 1'b0;
        abort8 = 1'b0;
        n_checks++;
        if ({ready8, valid8} !== 2'b10) begin
            n_fail++;
            $display("FAIL load_abort_idle: got rdy/vld=%b%b want 10", ready8, valid8);
        end
        step();
        n_checks++;
        if ({ready8, valid8, done8, ones8} !== {1'b1, 1'b0, 1'b0, 4'd3}) begin
            n_fail++;
            $display("FAIL load_abort_idle2: got rdy/vld/done=%b%b%b ones=%0d want 100 ones=3",
                     ready8, valid8, done8, ones8);
        end
    endtask

    task automatic test_load_ignored();
        logic [7:0] exp_seq;
        exp_seq = 8'hAA;
        conf8 = 8'hAA;
        load8 = 1'b1;
        step();
        load8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if ({valid8, bit8} !== {1'b1, exp_seq[7-i]}) begin
                n_fail++;
                $display("FAIL ignore_bit[%0d]: got vld/bit=%b%b want 1%b", i, valid8, bit8, exp_seq[7-i]);
            end
            if (i == 1) begin
                load8 = 1'b1;
                conf8 = 8'h01;
            end
            if (i == 4) load8 = 1'b0;
            step();
        end
        n_checks++;
        if ({done8, ones8, even8} !== {1'b1, 4'd4, 1'b1}) begin
            n_fail++;
            $display("FAIL ignore_done: got done=%b ones=%0d even=%b want done=1 ones=4 even=1", done8, ones8, even8);
        end
        step();
        step();
        n_checks++;
        if ({ready8, valid8} !== 2'b10) begin
            n_fail++;
            $display("FAIL ignore_noqueue: got rdy/vld=%b%b want 10", ready8, valid8);
        end
    endtask

    task automatic test_reset_mid_shift();
        conf8 = 8'hFF;
        load8 = 1'b1;
        step();
        load8 = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ready8, bit8, valid8, done8, ones8, even8} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_mid: got rdy/bit/vld/done/ones/even=%b%b%b%b/%0d/%b want 1000/0/1",
                     ready8, bit8, valid8, done8, ones8, even8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step();
        n_checks++;
        if ({ready8, valid8, done8, ones8} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL reset_mid_after: got rdy/vld/done=%b%b%b ones=%0d want 100 ones=0",
                     ready8, valid8, done8, ones8);
        end
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_back_to_back();
        test_lsb_first();
        test_abort();
        test_load_ignored();
        test_reset_mid_shift();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
